// File: rtl/led_morse_tx_pkg.sv
// Shared definitions for the LED-register Morse transmitter: FSM encoding,
// code/gap constants and the A-Z symbol lookup.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2,
      GAP   = 2'd3
   } morse_state_t;

   localparam logic [4:0] WORD_SPACE    = 5'd26;
   localparam logic [4:0] FIRST_INVALID = 5'd27;

   localparam logic [2:0] GAP_SYMBOL = 3'd1;
   localparam logic [2:0] GAP_CHAR   = 3'd3;
   localparam logic [2:0] GAP_WORD   = 3'd7;
   localparam logic [2:0] DOT_UNITS  = 3'd1;
   localparam logic [2:0] DASH_UNITS = 3'd3;

   // Unit-counter load value for a mark; the counter holds "units remaining - 1".
   function automatic logic [2:0] mark_units_m1(input logic is_dash);
      return is_dash ? (DASH_UNITS - 3'd1) : (DOT_UNITS - 3'd1);
   endfunction

   // Returns {len[2:0], pattern[3:0]}; pattern is left-aligned, 1 = dash.
   function automatic logic [6:0] morse_lut(input logic [4:0] code);
      logic [6:0] r;
      r = 7'd0;
      case (code)
         5'd0:  r = {3'd2, 4'b0100}; // A .-
         5'd1:  r = {3'd4, 4'b1000}; // B -...
         5'd2:  r = {3'd4, 4'b1010}; // C -.-.
         5'd3:  r = {3'd3, 4'b1000}; // D -..
         5'd4:  r = {3'd1, 4'b0000}; // E .
         5'd5:  r = {3'd4, 4'b0010}; // F ..-.
         5'd6:  r = {3'd3, 4'b1100}; // G --.
         5'd7:  r = {3'd4, 4'b0000}; // H ....
         5'd8:  r = {3'd2, 4'b0000}; // I ..
         5'd9:  r = {3'd4, 4'b0111}; // J .---
         5'd10: r = {3'd3, 4'b1010}; // K -.-
         5'd11: r = {3'd4, 4'b0100}; // L .-..
         5'd12: r = {3'd2, 4'b1100}; // M --
         5'd13: r = {3'd2, 4'b1000}; // N -.
         5'd14: r = {3'd3, 4'b1110}; // O ---
         5'd15: r = {3'd4, 4'b0110}; // P .--.
         5'd16: r = {3'd4, 4'b1101}; // Q --.-
         5'd17: r = {3'd3, 4'b0100}; // R .-.
         5'd18: r = {3'd3, 4'b0000}; // S ...
         5'd19: r = {3'd1, 4'b1000}; // T -
         5'd20: r = {3'd3, 4'b0010}; // U ..-
         5'd21: r = {3'd4, 4'b0001}; // V ...-
         5'd22: r = {3'd3, 4'b0110}; // W .--
         5'd23: r = {3'd4, 4'b1001}; // X -..-
         5'd24: r = {3'd4, 4'b1011}; // Y -.--
         5'd25: r = {3'd4, 4'b1100}; // Z --..
         default: r = 7'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/led_morse_tx_if.sv
// LED register bus into the transmitter and its keyed/status outputs.
interface led_morse_tx_if;
   logic [7:0] led_in;
   logic       morse_out;
   logic       busy;
   logic       done;

   modport master (output led_in, input morse_out, input busy, input done);
   modport slave  (input led_in, output morse_out, output busy, output done);
endinterface

// File: rtl/led_morse_tx_unit_prescaler.sv
// Divides clk down to a one-cycle unit_tick every CLKS_PER_UNIT cycles;
// clear restarts the count so a new phase gets a full first unit.
module unit_prescaler #(
   parameter int CLKS_PER_UNIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic unit_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_UNIT + 1);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_UNIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || (cnt == TERMINAL)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign unit_tick = (cnt == TERMINAL);

endmodule

// File: rtl/led_morse_tx.sv
// Serialises a 5-bit character code, strobed in through the LED register,
// as on/off-keyed Morse on morse_out with busy/done status.
module led_morse_tx #(
   parameter int CLKS_PER_UNIT = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   led_morse_tx_if.slave  bus
);
   import morse_pkg::*;

   morse_state_t state;
   logic         send_q;
   logic [2:0]   unit_cnt;
   logic [2:0]   len_q;
   logic [3:0]   pat_q;
   logic         morse_out_q;
   logic         busy_q;
   logic         done_q;

   logic [4:0]   code;
   logic [6:0]   lut;
   logic         accept;
   logic         unit_tick;
   logic         phase_end;
   logic         presc_clear;
   logic         unused_led;

   assign code       = bus.led_in[7:3];
   assign lut        = morse_lut(code);
   assign accept     = bus.led_in[2] & ~send_q & (state == IDLE);
   assign phase_end  = unit_tick & (unit_cnt == 3'd0);
   // Prescaler sits at zero while idle so the first unit after accept is full length.
   assign presc_clear = (state == IDLE) | phase_end;
   assign unused_led  = ^bus.led_in[1:0];

   unit_prescaler #(
      .CLKS_PER_UNIT (CLKS_PER_UNIT)
   ) u_prescaler (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (presc_clear),
      .unit_tick (unit_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         send_q      <= 1'b1;
         unit_cnt    <= 3'd0;
         len_q       <= 3'd0;
         pat_q       <= 4'd0;
         morse_out_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         send_q <= bus.led_in[2];
         done_q <= 1'b0;
         if (unit_tick && (unit_cnt != 3'd0)) begin
            unit_cnt <= unit_cnt - 3'd1;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  if (code < WORD_SPACE) begin
                     state       <= MARK;
                     len_q       <= lut[6:4];
                     pat_q       <= lut[3:0];
                     unit_cnt    <= mark_units_m1(lut[3]);
                     morse_out_q <= 1'b1;
                     busy_q      <= 1'b1;
                  end else if (code == WORD_SPACE) begin
                     state    <= GAP;
                     unit_cnt <= GAP_WORD - 3'd1;
                     busy_q   <= 1'b1;
                  end
                  // Codes FIRST_INVALID and above: strobe consumed, nothing sent.
               end
            end

            MARK: begin
               if (phase_end) begin
                  morse_out_q <= 1'b0;
                  pat_q       <= {pat_q[2:0], 1'b0};
                  len_q       <= len_q - 3'd1;
                  if (len_q > 3'd1) begin
                     state    <= SPACE;
                     unit_cnt <= GAP_SYMBOL - 3'd1;
                  end else begin
                     state    <= GAP;
                     unit_cnt <= GAP_CHAR - 3'd1;
                  end
               end
            end

            SPACE: begin
               if (phase_end) begin
                  state       <= MARK;
                  morse_out_q <= 1'b1;
                  unit_cnt    <= mark_units_m1(pat_q[3]);
               end
            end

            GAP: begin
               if (phase_end) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end

            default: begin
               state       <= IDLE;
               morse_out_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.morse_out = morse_out_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_led_morse_tx.sv
// Directed bench for led_morse_tx at CLKS_PER_UNIT=2: table of characters
// with hand-derived waveforms plus retrigger and mid-character reset sequences.
module tb_led_morse_tx;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   led_morse_tx_if bus ();

   led_morse_tx #(
      .CLKS_PER_UNIT (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  code;
      int          exp_busy;
      logic [63:0] exp_wave;
      int          exp_done;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Strobe a character (low then high on bit 2) and record busy length,
   // per-cycle morse_out while busy, done pulses and any mark outside busy.
   task automatic run_char(input logic [4:0] code, input bit hold, input int glitch,
                           output int bcyc, output logic [63:0] wave,
                           output int dones, output int stray, output bit fin);
      bit seen;
      bcyc  = 0;
      wave  = '0;
      dones = 0;
      stray = 0;
      fin   = 1'b0;
      seen  = 1'b0;
      bus.led_in = {code, 3'b000};
      @(negedge clk);
      bus.led_in = {code, 3'b100};
      for (int i = 0; i < 200 && !fin; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
         if (bus.busy) begin
            if (bcyc < 64) wave[bcyc] = bus.morse_out;
            bcyc++;
            seen = 1'b1;
         end else begin
            if (bus.morse_out) stray++;
            if (seen || i >= 3) fin = 1'b1;
         end
         if (!hold && i == 0) bus.led_in[2] = 1'b0;
         if (hold && i == glitch) bus.led_in[2] = 1'b0;
         if (hold && i == glitch + 1) bus.led_in[2] = 1'b1;
      end
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.morse_out) stray++;
   endtask

   initial begin
      int          bcyc;
      int          dones;
      int          stray;
      bit          fin;
      logic [63:0] wave;
      int          extra;

      checks = 0;
      errors = 0;

      vecs[0] = '{5'd4,  8,  64'h3,      1}; // E
      vecs[1] = '{5'd0,  16, 64'h3F3,    1}; // A
      vecs[2] = '{5'd26, 14, 64'h0,      1}; // word space
      vecs[3] = '{5'd18, 16, 64'h333,    1}; // S
      vecs[4] = '{5'd29, 0,  64'h0,      0}; // ignored code
      vecs[5] = '{5'd4,  8,  64'h3,      1}; // E right after ignored code
      vecs[6] = '{5'd12, 20, 64'h3F3F,   1}; // M
      vecs[7] = '{5'd14, 28, 64'h3F3F3F, 1}; // O

      rst_n      = 1'b0;
      bus.led_in = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_morse_out", {63'd0, bus.morse_out}, 64'd0);
      check("reset_busy",      {63'd0, bus.busy},      64'd0);
      check("reset_done",      {63'd0, bus.done},      64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         run_char(vecs[v].code, 1'b0, -1, bcyc, wave, dones, stray, fin);
         check($sformatf("v%0d_finished", v), {63'd0, fin}, 64'd1);
         check($sformatf("v%0d_busy_cycles", v), 64'(bcyc), 64'(vecs[v].exp_busy));
         check($sformatf("v%0d_wave", v), wave, vecs[v].exp_wave);
         check($sformatf("v%0d_done_count", v), 64'(dones), 64'(vecs[v].exp_done));
         check($sformatf("v%0d_stray_mark", v), 64'(stray), 64'd0);
      end

      // T with a second rising edge mid-dash and the strobe held high afterwards.
      run_char(5'd19, 1'b1, 3, bcyc, wave, dones, stray, fin);
      check("retrig_busy_cycles", 64'(bcyc), 64'd12);
      check("retrig_wave", wave, 64'h3F);
      check("retrig_done_count", 64'(dones), 64'd1);
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.busy || bus.morse_out || bus.done) extra++;
      end
      check("held_strobe_no_retrigger", 64'(extra), 64'd0);

      // Reset in the middle of a T dash with bit 2 still high on release.
      bus.led_in = {5'd19, 3'b000};
      @(negedge clk);
      bus.led_in = {5'd19, 3'b100};
      repeat (3) @(negedge clk);
      check("mid_dash_marking", {63'd0, bus.morse_out}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_morse_out", {63'd0, bus.morse_out}, 64'd0);
      check("abort_busy",      {63'd0, bus.busy},      64'd0);
      extra = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.done) extra++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.busy || bus.morse_out || bus.done) extra++;
      end
      check("post_reset_quiet", 64'(extra), 64'd0);

      run_char(5'd19, 1'b0, -1, bcyc, wave, dones, stray, fin);
      check("after_reset_T_busy", 64'(bcyc), 64'd12);
      check("after_reset_T_wave", wave, 64'h3F);
      check("after_reset_T_done", 64'(dones), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
